load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Multi-cycle memory-access stage between the instruction decoder/register file and BRAM port B.
- Executes one load or store per request: latches address into MAR and store data into MDR, then drives the port-B signals.
- Waits the BRAM read latency, captures load data, and returns it with its destination register index for register-file writeback.
- Lets the control FSM treat data memory as a valid/ready handshake instead of open-coded enable sequencing.

Parameters:
- ADDR_W, 16, memory word-address width
- DATA_W, 16, data word width
- RD_LAT, 1, BRAM read latency in cycles from address sample to valid mem_rdata; legal range 1..4

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request this cycle
- req_store  input  1  1 = store, 0 = load; sampled on accept
- req_addr  input  ADDR_W  word address; sampled on accept
- req_wdata  input  DATA_W  store data; sampled on accept
- req_rdest  input  4  load destination register index; sampled on accept
- mem_en  output  1  BRAM port-B enable
- mem_we  output  1  BRAM port-B write enable
- mem_addr  output  ADDR_W  BRAM port-B address (MAR)
- mem_wdata  output  DATA_W  BRAM port-B write data (MDR)
- mem_rdata  input  DATA_W  BRAM port-B read data
- wb_valid  output  1  one-cycle writeback strobe (loads only)
- wb_rdest  output  4  writeback register index
- wb_data  output  DATA_W  loaded data
- done  output  1  one-cycle completion pulse (loads and stores)
- busy  output  1  state != IDLE

Behaviour:
- States: IDLE, ACCESS, WAIT, RESP. Registers: state, MAR, MDR, rdest_q, store_q, wait counter.
- Reset low, asynchronous:
  - Immediately: state=IDLE; MAR, MDR, rdest_q, store_q, counter = 0.
  - Every output is 0, including req_ready, which is forced 0 while reset is low.
  - mem_en, mem_we, mem_addr and mem_wdata are decoded from registers, so they drop within the same cycle reset asserts.
- IDLE:
  - req_ready=1.
  - Accept on rising edge with req_valid & req_ready: MAR<=req_addr, MDR<=req_wdata, rdest_q<=req_rdest, store_q<=req_store; go to ACCESS.
- ACCESS: exactly one cycle; mem_en=1, mem_we=store_q, mem_addr=MAR, mem_wdata=MDR.
  - Store: go to RESP.
  - Load: counter<=RD_LAT-1; go to WAIT.
- WAIT:
  - mem_en=0; counter decrements each cycle.
  - When counter==0: MDR<=mem_rdata, go to RESP.
  - WAIT lasts RD_LAT cycles.
- RESP: one cycle; done=1. For loads, wb_valid=1, wb_rdest=rdest_q, wb_data=MDR. Go to IDLE.
- Latency, acceptance edge = edge 0, cycle n = cycle after edge n-1:
  - Store: mem_we high in cycle 1 only; done in cycle 2.
  - Load: done and wb_valid in cycle 2+RD_LAT.
  - Next accept is possible at the end of the first IDLE cycle after RESP.
- req_ready=0 in every non-IDLE state. A requester must hold req_valid and its fields until accepted. Requests presented while busy are neither lost nor duplicated.
- Request fields may change after the accept edge without effect.
- wb_data and wb_rdest hold their values after RESP until the next load's RESP. wb_valid is never asserted for stores.
- mem_addr and mem_wdata hold MAR/MDR in all states; only mem_en and mem_we qualify them.
- Addresses pass unmodified: no alignment, no wrap or range checks. 0xFFFF is legal.
- Reset during ACCESS of a store: mem_we drops asynchronously, the write is not committed, and no done pulse occurs.
- Reset during WAIT: captured data is discarded and no wb_valid occurs.
- RD_LAT outside 1..4: elaboration error.

Test Plan:
- Reset: hold reset low 3 cycles with req_valid=1 -> all outputs 0, req_ready=0. Release -> req_ready=1, busy=0.
- Store: req_store=1, addr=0x0010, wdata=0x00A5 accepted at edge 0 -> cycle 1: mem_en=1, mem_we=1, mem_addr=0x0010, mem_wdata=0x00A5. Cycle 2: done=1, wb_valid=0. Cycle 3: req_ready=1.
- Load, RD_LAT=1: BRAM model holds 0x00A5 at 0x0010; load addr=0x0010, rdest=3 -> cycle 1: mem_en=1, mem_we=0. Cycle 3: wb_valid=1, wb_rdest=3, wb_data=0x00A5, done=1. wb_data stays 0x00A5 afterwards.
- Load, RD_LAT=3 at addr 0xFFFF -> mem_addr=0xFFFF; wb_valid in cycle 5 exactly. mem_rdata garbage during cycles 2-3 is not captured.
- Back-to-back: req_valid held high, store then load queued -> second request accepted only at the first edge with req_ready=1. Exactly one mem_we cycle and one wb_valid pulse in total.
- Reset mid-op: assert reset in the middle of the store's ACCESS cycle -> mem_we=0 immediately, BRAM model unchanged, no done. After release: state IDLE, req_ready=1.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: multi-cycle memory-access stage between the decoder /
// register file and BRAM port B. One load or store per request, presented
// to the control FSM as a valid/ready handshake. Loads return their data
// together with the destination register index for writeback.
module load_store_unit #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [3:0]        req_rdest,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_valid,
    output logic [3:0]        wb_rdest,
    output logic [DATA_W-1:0] wb_data,
    output logic              done,
    output logic              busy
);

    // Read latencies beyond the 2-bit wait counter are rejected at elaboration.
    generate
        if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
            $error("load_store_unit: RD_LAT must be in 1..4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Counter preload: WAIT spans exactly RD_LAT cycles, ending at count 0.
    localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

    state_t            state_r;
    logic [ADDR_W-1:0] mar_r;
    logic [DATA_W-1:0] mdr_r;
    logic [3:0]        rdest_r;
    logic              store_r;
    logic [1:0]        cnt_r;
    logic [DATA_W-1:0] wb_data_r;
    logic [3:0]        wb_rdest_r;

    // Sequencer: accept, single access cycle, read-latency wait, response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            mar_r      <= '0;
            mdr_r      <= '0;
            rdest_r    <= 4'd0;
            store_r    <= 1'b0;
            cnt_r      <= 2'd0;
            wb_data_r  <= '0;
            wb_rdest_r <= 4'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        mar_r   <= req_addr;
                        mdr_r   <= req_wdata;
                        rdest_r <= req_rdest;
                        store_r <= req_store;
                        state_r <= ACCESS;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACCESS: begin
                    if (store_r) begin
                        state_r <= RESP;
                    end else begin
                        cnt_r   <= CNT_INIT;
                        state_r <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_r == 2'd0) begin
                        // Writeback copies are kept apart from MDR so they
                        // survive the next accept until the next load returns.
                        mdr_r      <= mem_rdata;
                        wb_data_r  <= mem_rdata;
                        wb_rdest_r <= rdest_r;
                        state_r    <= RESP;
                    end else begin
                        cnt_r <= cnt_r - 2'd1;
                    end
                end
                RESP: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Port-B and status decode straight from registers, so an asynchronous
    // reset drops them within the same cycle; req_ready is also gated by
    // reset because the reset state is IDLE.
    assign req_ready = reset && (state_r == IDLE);
    assign busy      = (state_r != IDLE);
    assign mem_en    = (state_r == ACCESS);
    assign mem_we    = (state_r == ACCESS) && store_r;
    assign mem_addr  = mar_r;
    assign mem_wdata = mdr_r;
    assign done      = (state_r == RESP);
    assign wb_valid  = (state_r == RESP) && !store_r;
    assign wb_rdest  = wb_rdest_r;
    assign wb_data   = wb_data_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: two instances (RD_LAT=1 and RD_LAT=3), each
// with a BRAM model, a timeline-based reference model and a per-cycle
// comparison, plus hand-computed literal checks from directed vectors.
module tb_load_store_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid [2];
    logic        req_store [2];
    logic [15:0] req_addr  [2];
    logic [15:0] req_wdata [2];
    logic [3:0]  req_rdest [2];
    logic        req_ready [2];
    logic        mem_en    [2];
    logic        mem_we    [2];
    logic [15:0] mem_addr  [2];
    logic [15:0] mem_wdata [2];
    logic [15:0] mem_rdata [2];
    logic        wb_valid  [2];
    logic [3:0]  wb_rdest  [2];
    logic [15:0] wb_data   [2];
    logic        done      [2];
    logic        busy      [2];

    int total = 0;
    int bad   = 0;

    load_store_unit #(.ADDR_W(16), .DATA_W(16), .RD_LAT(1)) u_lat1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_store(req_store[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_rdest(req_rdest[0]),
        .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]),
        .wb_valid(wb_valid[0]), .wb_rdest(wb_rdest[0]), .wb_data(wb_data[0]),
        .done(done[0]), .busy(busy[0])
    );

    load_store_unit #(.ADDR_W(16), .DATA_W(16), .RD_LAT(3)) u_lat3 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_store(req_store[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_rdest(req_rdest[1]),
        .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]),
        .wb_valid(wb_valid[1]), .wb_rdest(wb_rdest[1]), .wb_data(wb_data[1]),
        .done(done[1]), .busy(busy[1])
    );

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[dut%0d] t=%0t got=%h want=%h", nm, d, $time, act, exp);
        end
    endtask

    // ---------------- BRAM models (read latency 1 and 3) ----------------
    logic [15:0] bram [2][65536];
    logic [15:0] pd   [2][4];
    logic        pv   [2][4];
    logic        pre_en;
    int          pre_d;
    logic [15:0] pre_addr;
    logic [15:0] pre_data;

    // Synchronous BRAM: writes on enable+we, reads travel a latency pipeline.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            for (int k = 1; k < 4; k++) begin
                pd[d][k] <= pd[d][k-1];
                pv[d][k] <= pv[d][k-1];
            end
            pv[d][0] <= mem_en[d] && !mem_we[d];
            pd[d][0] <= bram[d][mem_addr[d]];
            if (mem_en[d] && mem_we[d]) bram[d][mem_addr[d]] <= mem_wdata[d];
        end
        if (pre_en) bram[pre_d][pre_addr] <= pre_data;
    end

    // Outside the valid read slot the BRAM presents garbage.
    assign mem_rdata[0] = pv[0][0] ? pd[0][0] : 16'hBEEF;
    assign mem_rdata[1] = pv[1][2] ? pd[1][2] : 16'hBEEF;

    // ---------------- reference model ----------------
    // Each operation is a timeline: cycle t=1 after the accept edge is the
    // memory access, the response is cycle 2 (store) or 2+latency (load).
    bit          m_act [2] = '{1'b0, 1'b0};
    int          m_t   [2] = '{0, 0};
    bit          m_st  [2] = '{1'b0, 1'b0};
    logic [15:0] m_mar [2] = '{16'h0, 16'h0};
    logic [15:0] m_mdr [2] = '{16'h0, 16'h0};
    logic [15:0] m_ld  [2] = '{16'h0, 16'h0};
    logic [15:0] m_wbd [2] = '{16'h0, 16'h0};
    logic [3:0]  m_rd  [2] = '{4'h0, 4'h0};
    logic [3:0]  m_wbr [2] = '{4'h0, 4'h0};
    int          we_cnt [2] = '{0, 0};
    int          wbv_cnt[2] = '{0, 0};
    int          dn_cnt [2] = '{0, 0};

    // Advance the model one cycle per rising edge.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int last;
            last = m_st[d] ? 2 : 2 + lat_of(d);
            if (!reset) begin
                m_act[d] = 1'b0; m_t[d] = 0; m_st[d] = 1'b0;
                m_mar[d] = 16'h0; m_mdr[d] = 16'h0; m_wbd[d] = 16'h0;
                m_rd[d] = 4'h0; m_wbr[d] = 4'h0;
            end else if (m_act[d]) begin
                m_t[d]++;
                if (!m_st[d] && m_t[d] == 2 + lat_of(d)) begin
                    m_mdr[d] = m_ld[d];
                    m_wbd[d] = m_ld[d];
                    m_wbr[d] = m_rd[d];
                end
                if (m_t[d] > last) m_act[d] = 1'b0;
            end else if (req_valid[d]) begin
                m_act[d] = 1'b1; m_t[d] = 1;
                m_st[d] = req_store[d]; m_mar[d] = req_addr[d];
                m_mdr[d] = req_wdata[d]; m_rd[d] = req_rdest[d];
                m_ld[d] = bram[d][req_addr[d]];
            end
        end
    end

    // Compare every output of both instances against the model each cycle.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            bit on, acc, resp;
            on   = reset;
            acc  = m_act[d] && m_t[d] == 1;
            resp = m_act[d] && m_t[d] == (m_st[d] ? 2 : 2 + lat_of(d));
            chk("req_ready", d, 32'(req_ready[d]), 32'(on && !m_act[d]));
            chk("busy",      d, 32'(busy[d]),      32'(on && m_act[d]));
            chk("mem_en",    d, 32'(mem_en[d]),    32'(on && acc));
            chk("mem_we",    d, 32'(mem_we[d]),    32'(on && acc && m_st[d]));
            chk("mem_addr",  d, 32'(mem_addr[d]),  on ? 32'(m_mar[d]) : 32'h0);
            chk("mem_wdata", d, 32'(mem_wdata[d]), on ? 32'(m_mdr[d]) : 32'h0);
            chk("done",      d, 32'(done[d]),      32'(on && resp));
            chk("wb_valid",  d, 32'(wb_valid[d]),  32'(on && resp && !m_st[d]));
            chk("wb_rdest",  d, 32'(wb_rdest[d]),  on ? 32'(m_wbr[d]) : 32'h0);
            chk("wb_data",   d, 32'(wb_data[d]),   on ? 32'(m_wbd[d]) : 32'h0);
            if (mem_we[d])   we_cnt[d]++;
            if (wb_valid[d]) wbv_cnt[d]++;
            if (done[d])     dn_cnt[d]++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic preload(input int d, input logic [15:0] a, input logic [15:0] v);
        @(negedge clk);
        pre_en = 1'b1; pre_d = d; pre_addr = a; pre_data = v;
        @(posedge clk);
        #1 pre_en = 1'b0;
    endtask

    // Present a request and hold it until accepted; returns inside cycle 1.
    task automatic do_req(input int d, input bit st, input logic [15:0] a,
                          input logic [15:0] wd, input logic [3:0] rd, input bit keep);
        int n;
        @(negedge clk);
        req_valid[d] = 1'b1; req_store[d] = st; req_addr[d] = a;
        req_wdata[d] = wd; req_rdest[d] = rd;
        n = 0;
        while (!req_ready[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            total++; bad++;
            $display("FAIL accept_timeout[dut%0d] got=not_ready want=ready", d);
        end
        @(posedge clk);
        #1;
        if (!keep) begin
            req_valid[d] = 1'b0;
            req_store[d] = 1'($urandom);
            req_addr[d]  = 16'($urandom);
            req_wdata[d] = 16'($urandom);
            req_rdest[d] = 4'($urandom);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int we0, wbv0, dn0;
        reset = 1'b0; pre_en = 1'b0; pre_d = 0; pre_addr = 16'h0; pre_data = 16'h0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b1; req_store[d] = 1'b1; req_addr[d] = 16'h1234;
            req_wdata[d] = 16'h5678; req_rdest[d] = 4'h5;
        end
        for (int d = 0; d < 2; d++) for (int k = 0; k < 4; k++) begin
            pd[d][k] = 16'h0; pv[d][k] = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk("rst_ready_lit", 0, 32'(req_ready[0]), 32'h0);
        chk("rst_en_lit",    1, 32'(mem_en[1]),    32'h0);
        #2 reset = 1'b1;
        req_valid[0] = 1'b0; req_valid[1] = 1'b0;
        #1;
        chk("post_rst_ready_lit", 0, 32'(req_ready[0]), 32'h1);
        chk("post_rst_busy_lit",  1, 32'(busy[1]),      32'h0);

        preload(0, 16'h0020, 16'h1111);
        preload(1, 16'hFFFF, 16'h5A3C);

        // Store 0x00A5 -> 0x0010 on the latency-1 unit.
        do_req(0, 1'b1, 16'h0010, 16'h00A5, 4'd0, 1'b0);
        @(negedge clk);
        chk("st_c1_en_lit",    0, 32'(mem_en[0]),    32'h1);
        chk("st_c1_we_lit",    0, 32'(mem_we[0]),    32'h1);
        chk("st_c1_addr_lit",  0, 32'(mem_addr[0]),  32'h0010);
        chk("st_c1_wdata_lit", 0, 32'(mem_wdata[0]), 32'h00A5);
        @(negedge clk);
        chk("st_c2_done_lit",  0, 32'(done[0]),      32'h1);
        chk("st_c2_wbv_lit",   0, 32'(wb_valid[0]),  32'h0);
        @(negedge clk);
        chk("st_c3_ready_lit", 0, 32'(req_ready[0]), 32'h1);
        chk("st_bram_lit",     0, 32'(bram[0][16'h0010]), 32'h00A5);

        // Load it back into r3.
        do_req(0, 1'b0, 16'h0010, 16'h0000, 4'd3, 1'b0);
        @(negedge clk);
        chk("ld_c1_en_lit",  0, 32'(mem_en[0]),   32'h1);
        chk("ld_c1_we_lit",  0, 32'(mem_we[0]),   32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("ld_c3_wbv_lit",  0, 32'(wb_valid[0]), 32'h1);
        chk("ld_c3_rd_lit",   0, 32'(wb_rdest[0]), 32'h3);
        chk("ld_c3_data_lit", 0, 32'(wb_data[0]),  32'h00A5);
        chk("ld_c3_done_lit", 0, 32'(done[0]),     32'h1);
        @(negedge clk);
        chk("ld_hold_lit",    0, 32'(wb_data[0]),  32'h00A5);

        // Latency-3 load from the top of the address space.
        do_req(1, 1'b0, 16'hFFFF, 16'h0000, 4'd7, 1'b0);
        @(negedge clk);
        chk("l3_c1_addr_lit", 1, 32'(mem_addr[1]), 32'hFFFF);
        @(negedge clk); @(negedge clk); @(negedge clk);
        chk("l3_c4_wbv_lit",  1, 32'(wb_valid[1]), 32'h0);
        @(negedge clk);
        chk("l3_c5_wbv_lit",  1, 32'(wb_valid[1]), 32'h1);
        chk("l3_c5_data_lit", 1, 32'(wb_data[1]),  32'h5A3C);
        chk("l3_c5_rd_lit",   1, 32'(wb_rdest[1]), 32'h7);

        // Back-to-back: store then load with req_valid held high throughout.
        repeat (2) @(negedge clk);
        we0 = we_cnt[1]; wbv0 = wbv_cnt[1]; dn0 = dn_cnt[1];
        do_req(1, 1'b1, 16'h0100, 16'hC3C3, 4'd0, 1'b1);
        do_req(1, 1'b0, 16'h0100, 16'h0000, 4'd9, 1'b0);
        repeat (10) @(negedge clk);
        chk("b2b_we_cnt",   1, 32'(we_cnt[1] - we0),   32'd1);
        chk("b2b_wbv_cnt",  1, 32'(wbv_cnt[1] - wbv0), 32'd1);
        chk("b2b_done_cnt", 1, 32'(dn_cnt[1] - dn0),   32'd2);
        chk("b2b_data_lit", 1, 32'(wb_data[1]),  32'hC3C3);
        chk("b2b_rd_lit",   1, 32'(wb_rdest[1]), 32'h9);

        // Reset in the middle of a store's access cycle.
        dn0 = dn_cnt[0];
        do_req(0, 1'b1, 16'h0020, 16'h7777, 4'd0, 1'b0);
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        chk("mid_rst_we_lit",    0, 32'(mem_we[0]),    32'h0);
        chk("mid_rst_en_lit",    0, 32'(mem_en[0]),    32'h0);
        chk("mid_rst_ready_lit", 0, 32'(req_ready[0]), 32'h0);
        @(negedge clk); @(negedge clk);
        #2 reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_rst_bram_lit",  0, 32'(bram[0][16'h0020]), 32'h1111);
        chk("mid_rst_no_done",   0, 32'(dn_cnt[0] - dn0),   32'd0);
        chk("mid_rst_ready_lit2",0, 32'(req_ready[0]),      32'h1);
        chk("mid_rst_busy_lit",  0, 32'(busy[0]),           32'h0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
